// File: rtl/systolic_skew_feeder_if.sv
// Write port, feed control and per-row operand outputs of the systolic skew feeder.
// The master side is the buffer loader / PE array; the slave side is the feeder.
interface systolic_skew_feeder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_ROWS   = 4,
   parameter int DEPTH      = 4
);
   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                           wr_en;
   logic                           wr_side;
   logic [ROW_W-1:0]               wr_row;
   logic [IDX_W-1:0]               wr_idx;
   logic [DATA_WIDTH-1:0]          wr_data;
   logic                           start;
   logic                           stall;
   logic                           noskew;
   logic [NUM_ROWS*DATA_WIDTH-1:0] a_out;
   logic [NUM_ROWS*DATA_WIDTH-1:0] b_out;
   logic [NUM_ROWS-1:0]            a_valid;
   logic [NUM_ROWS-1:0]            b_valid;
   logic                           busy;
   logic                           done;

   modport master (
      output wr_en, wr_side, wr_row, wr_idx, wr_data, start, stall, noskew,
      input  a_out, b_out, a_valid, b_valid, busy, done
   );

   modport slave (
      input  wr_en, wr_side, wr_row, wr_idx, wr_data, start, stall, noskew,
      output a_out, b_out, a_valid, b_valid, busy, done
   );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers A/B operand vectors per row and streams them into a PE array, either
// diagonally skewed (row r delayed by r steps) or with all rows aligned.
module systolic_skew_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_ROWS   = 4,
   parameter int DEPTH      = 4
) (
   input logic                   clk,
   input logic                   reset,
   systolic_skew_feeder_if.slave bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + NUM_ROWS);
   localparam int OUT_W = NUM_ROWS * DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_r, state_s;
   logic [CNT_W-1:0]      t_r, t_s;
   logic                  mode_r, mode_s;
   logic [OUT_W-1:0]      a_out_r, a_out_s, b_out_r, b_out_s;
   logic [NUM_ROWS-1:0]   a_valid_r, a_valid_s, b_valid_r, b_valid_s;
   logic                  busy_r, busy_s, done_r, done_s;
   logic [OUT_W-1:0]      a_step_s, b_step_s;
   logic [NUM_ROWS-1:0]   v_step_s;
   logic                  last_s, wr_ok_s;
   int                    k_s [NUM_ROWS];
   logic [DATA_WIDTH-1:0] bufa_r [NUM_ROWS][DEPTH];
   logic [DATA_WIDTH-1:0] bufb_r [NUM_ROWS][DEPTH];

   // Buffer writes are accepted only in IDLE and only for in-range addresses.
   assign wr_ok_s = (state_r == IDLE) && bus.wr_en &&
                    (32'(bus.wr_row) < NUM_ROWS) && (32'(bus.wr_idx) < DEPTH);

   // Operand buffers: cleared by reset, loaded through the write port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
               bufa_r[r][k] <= '0;
               bufb_r[r][k] <= '0;
            end
         end
      end else if (wr_ok_s) begin
         if (bus.wr_side) begin
            bufb_r[bus.wr_row][bus.wr_idx] <= bus.wr_data;
         end else begin
            bufa_r[bus.wr_row][bus.wr_idx] <= bus.wr_data;
         end
      end
   end

   // Element selected for each row at the current step; rows outside their window idle at 0.
   always_comb begin
      a_step_s = '0;
      b_step_s = '0;
      v_step_s = '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
         k_s[r] = mode_r ? int'(t_r) : int'(t_r) - r;
         if ((k_s[r] >= 0) && (k_s[r] < DEPTH)) begin
            a_step_s[r*DATA_WIDTH +: DATA_WIDTH] = bufa_r[r][k_s[r][IDX_W-1:0]];
            b_step_s[r*DATA_WIDTH +: DATA_WIDTH] = bufb_r[r][k_s[r][IDX_W-1:0]];
            v_step_s[r] = 1'b1;
         end else begin
            v_step_s[r] = 1'b0;
         end
      end
   end

   // Final step index depends on the mode latched at start.
   assign last_s = mode_r ? (int'(t_r) == DEPTH - 1) : (int'(t_r) == DEPTH + NUM_ROWS - 2);

   // Sequencer next state and next output values.
   always_comb begin
      state_s   = state_r;
      t_s       = t_r;
      mode_s    = mode_r;
      a_out_s   = a_out_r;
      b_out_s   = b_out_r;
      a_valid_s = a_valid_r;
      b_valid_s = b_valid_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_s = RUN;
               t_s     = '0;
               mode_s  = bus.noskew;
               busy_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (!bus.stall) begin
               a_out_s   = a_step_s;
               b_out_s   = b_step_s;
               a_valid_s = v_step_s;
               b_valid_s = v_step_s;
               t_s       = t_r + CNT_W'(1);
               if (last_s) begin
                  state_s = DONE;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            state_s   = IDLE;
            a_out_s   = '0;
            b_out_s   = '0;
            a_valid_s = '0;
            b_valid_s = '0;
            busy_s    = 1'b0;
            done_s    = 1'b1;
         end
         default: begin
            state_s   = IDLE;
            a_out_s   = '0;
            b_out_s   = '0;
            a_valid_s = '0;
            b_valid_s = '0;
            busy_s    = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         t_r       <= '0;
         mode_r    <= 1'b0;
         a_out_r   <= '0;
         b_out_r   <= '0;
         a_valid_r <= '0;
         b_valid_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         t_r       <= t_s;
         mode_r    <= mode_s;
         a_out_r   <= a_out_s;
         b_out_r   <= b_out_s;
         a_valid_r <= a_valid_s;
         b_valid_r <= b_valid_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign bus.a_out   = a_out_r;
   assign bus.b_out   = b_out_r;
   assign bus.a_valid = a_valid_r;
   assign bus.b_valid = b_valid_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder at default parameters: skew, aligned,
// stall, ignored writes/starts, same-edge start+write, and mid-run reset.
module tb_systolic_skew_feeder;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   passed = 0;
   logic [31:0] ma [4][4];
   logic [31:0] mb [4][4];

   systolic_skew_feeder_if #(.DATA_WIDTH(32), .NUM_ROWS(4), .DEPTH(4)) bus ();

   systolic_skew_feeder #(.DATA_WIDTH(32), .NUM_ROWS(4), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [127:0] exp_data(input bit side, input int step, input bit aligned);
      logic [127:0] v = '0;
      for (int r = 0; r < 4; r++) begin
         int k = aligned ? step : step - r;
         if (k >= 0 && k < 4) v[r*32 +: 32] = side ? mb[r][k] : ma[r][k];
      end
      return v;
   endfunction

   function automatic logic [3:0] exp_valid(input int step, input bit aligned);
      logic [3:0] v = '0;
      for (int r = 0; r < 4; r++) begin
         int k = aligned ? step : step - r;
         v[r] = (k >= 0 && k < 4);
      end
      return v;
   endfunction

   task automatic step_checks(input int s, input bit aligned);
      check($sformatf("a_out_s%0d", s), bus.a_out, exp_data(1'b0, s, aligned));
      check($sformatf("b_out_s%0d", s), bus.b_out, exp_data(1'b1, s, aligned));
      check($sformatf("a_valid_s%0d", s), bus.a_valid, exp_valid(s, aligned));
      check($sformatf("b_valid_s%0d", s), bus.b_valid, exp_valid(s, aligned));
      check($sformatf("busy_s%0d", s), bus.busy, 1'b1);
      check($sformatf("done_s%0d", s), bus.done, 1'b0);
   endtask

   task automatic launch(input bit aligned);
      bus.start  = 1'b1;
      bus.noskew = aligned;
      tick();
      bus.start  = 1'b0;
      bus.noskew = 1'b0;
      check("busy_after_start", bus.busy, 1'b1);
      check("valid_after_start", bus.a_valid, 4'h0);
   endtask

   task automatic run_steps(input int first, input int last, input bit aligned);
      for (int s = first; s <= last; s++) begin
         tick();
         step_checks(s, aligned);
      end
   endtask

   task automatic finish_checks();
      tick();
      check("done_pulse", bus.done, 1'b1);
      check("busy_at_done", bus.busy, 1'b0);
      check("a_out_zero_at_done", bus.a_out, 128'h0);
      check("valid_zero_at_done", {bus.a_valid, bus.b_valid}, 8'h00);
      tick();
      check("done_single_cycle", bus.done, 1'b0);
      check("busy_idle", bus.busy, 1'b0);
   endtask

   task automatic wr(input bit side, input int row, input int idx, input logic [31:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_side = side;
      bus.wr_row  = row[1:0];
      bus.wr_idx  = idx[1:0];
      bus.wr_data = data;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_side = 1'b0;
      bus.wr_row  = 2'd0;
      bus.wr_idx  = 2'd0;
      bus.wr_data = 32'h0;
      bus.start   = 1'b0;
      bus.stall   = 1'b0;
      bus.noskew  = 1'b0;
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_out", bus.a_out, 128'h0);
      check("rst_b_out", bus.b_out, 128'h0);
      check("rst_valid", {bus.a_valid, bus.b_valid}, 8'h00);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      reset = 1'b1;

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            ma[r][k] = 32'(16 * r + k);
            mb[r][k] = 32'(256 + 16 * r + k);
            wr(1'b0, r, k, ma[r][k]);
            wr(1'b1, r, k, mb[r][k]);
         end
      end

      // Skewed run: seven steps, row r live on steps r..r+3.
      launch(1'b0);
      for (int s = 0; s <= 6; s++) begin
         tick();
         step_checks(s, 1'b0);
         if (s == 3) check("skew_step3_literal", bus.a_out, 128'h00000030_00000021_00000012_00000003);
      end
      finish_checks();

      // Aligned run: four steps, every row valid throughout.
      launch(1'b1);
      for (int s = 0; s <= 3; s++) begin
         tick();
         step_checks(s, 1'b1);
         check($sformatf("aligned_valid_s%0d", s), bus.a_valid, 4'hF);
      end
      finish_checks();

      // Stall after step 2 for three cycles; write and start during RUN are ignored.
      launch(1'b0);
      run_steps(0, 2, 1'b0);
      bus.stall   = 1'b1;
      bus.start   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_side = 1'b0;
      bus.wr_row  = 2'd1;
      bus.wr_idx  = 2'd2;
      bus.wr_data = 32'h0000DEAD;
      for (int i = 0; i < 3; i++) begin
         tick();
         step_checks(2, 1'b0);
      end
      bus.stall = 1'b0;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      run_steps(3, 6, 1'b0);
      finish_checks();

      launch(1'b1);
      for (int s = 0; s <= 3; s++) begin
         tick();
         step_checks(s, 1'b1);
         if (s == 2) check("a12_unchanged", bus.a_out[63:32], 32'h00000012);
      end
      finish_checks();

      // Start, write and stall on the same IDLE edge.
      bus.wr_en   = 1'b1;
      bus.wr_side = 1'b0;
      bus.wr_row  = 2'd0;
      bus.wr_idx  = 2'd0;
      bus.wr_data = 32'h0000ABCD;
      bus.stall   = 1'b1;
      ma[0][0]    = 32'h0000ABCD;
      launch(1'b1);
      bus.wr_en = 1'b0;
      bus.stall = 1'b0;
      run_steps(0, 0, 1'b1);
      check("same_edge_write_step0", bus.a_out[31:0], 32'h0000ABCD);
      run_steps(1, 3, 1'b1);
      finish_checks();

      // Reset mid-run: outputs clear at once, no done pulse, buffers cleared.
      launch(1'b0);
      run_steps(0, 4, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("midrst_a_out", bus.a_out, 128'h0);
      check("midrst_b_out", bus.b_out, 128'h0);
      check("midrst_valid", {bus.a_valid, bus.b_valid}, 8'h00);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_done", bus.done, 1'b0);
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 4; k++) begin
            ma[r][k] = 32'h0;
            mb[r][k] = 32'h0;
         end
      end
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("no_done_after_rst_%0d", i), {bus.done, bus.busy}, 2'b00);
      end
      launch(1'b1);
      run_steps(0, 3, 1'b1);
      finish_checks();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
